fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Program counter, two-part instruction register and memory-address mux of the accumulator CPU datapath.
//  Sits directly downstream of the main controller: it consumes pcWrite, memAddressSel, IRwritePart1 and IRwritePart2.
//  It feeds upcode back to the controller and drives the memory address bus.
//  It also tracks the fetch phase and flags illegal IR load sequences.
// PARAMETERS
//  DATA_W   8    memory word width; only 8 is supported (the IR byte format below assumes it)
//  ADDR_W   12   memory address width = 4 high bits from byte 1 + DATA_W low bits from byte 2
//  RESET_PC 0    PC value after reset
// PORTS
//  clk           in   1       rising-edge clock
//  rst           in   1       synchronous, active-high reset
//  pcWrite       in   1       increment PC this cycle
//  pcLoad        in   1       load PC from pcLoadValue; has priority over pcWrite
//  pcLoadValue   in   ADDR_W  jump target
//  memAddressSel in   1       0: memAddress=pc, 1: memAddress=operand address
//  IRwritePart1  in   1       capture memData into ir1 (opcode byte)
//  IRwritePart2  in   1       capture memData into ir2 (address low byte)
//  memData       in   DATA_W  memory read data
//  memAddress    out  ADDR_W  combinational mux output
//  upcode        out  4       ir1[7:4]
//  operandAddr   out  ADDR_W  {ir1[3:0], ir2}
//  pc            out  ADDR_W  current PC
//  irValid       out  1       opcode byte held for the current instruction
//  operandValid  out  1       operand byte also held
//  seqError      out  1       sticky illegal-sequence flag
// BEHAVIOUR
//  Reset values (on clk edge with rst=1): pc=RESET_PC, ir1=0, ir2=0, irValid=0, operandValid=0, seqError=0, phase=IDLE.
//  rst overrides every other input in the same cycle.
//  PC: pcLoad=1 -> pc<=pcLoadValue. Otherwise pcWrite=1 -> pc<=pc+1, modulo 2^ADDR_W (4095 wraps to 0).
//  PC: when neither is asserted, pc holds.
//  IR writes take effect on the next edge; upcode and operandAddr are therefore valid the cycle after the write.
//  memAddress is purely combinational from memAddressSel, pc, ir1 and ir2; it has no latency.
//  Phase FSM (states IDLE, HAVE_OP, HAVE_ADDR):
//   IDLE      + P1 -> HAVE_OP; ir1 captured; irValid=1.
//   HAVE_OP   + P2 -> HAVE_ADDR; ir2 captured; operandValid=1.
//   HAVE_OP   + P1 -> HAVE_OP; ir1 recaptured (a one-byte instruction followed by the next fetch); operandValid=0.
//   HAVE_ADDR + P1 -> HAVE_OP; ir1 captured; operandValid=0 (next instruction).
//   IDLE      + P2 -> seqError=1; ir2 not written; state stays IDLE.
//   HAVE_ADDR + P2 -> seqError=1; ir2 not written; state stays HAVE_ADDR.
//   P1 and P2 in the same cycle -> seqError=1; neither IR register is written; state unchanged.
//   P1 and P2 in the same cycle do not block the PC update.
//  irValid = (phase != IDLE); operandValid = (phase == HAVE_ADDR). Both are registered.
//  seqError stays set until rst.
//  pcLoad/pcWrite are independent of the phase FSM, so a PC update may coincide with any IR write.
// TESTING
//  1. rst=1 for one edge with random inputs -> pc=0, upcode=0, irValid=0, operandValid=0, seqError=0.
//  2. Two-byte fetch: memData=8'h2A with P1+pcWrite, then memData=8'h5C with P2+pcWrite ->
//     upcode=4'h2, operandAddr=12'hA5C, pc=2, operandValid=1; memAddressSel=1 -> memAddress=12'hA5C.
//  3. pcLoad=1 with pcLoadValue=12'hFFF, then pcWrite=1 -> pc=0 (wrap).
//     pcLoad and pcWrite together with pcLoadValue=12'h123 -> pc=12'h123.
//  4. IRwritePart2 right after reset -> seqError=1, ir2 unchanged, irValid=0.
//     Then P1 with memData=8'h80 -> upcode=4'h8, seqError still 1.
//  5. P1 and P2 together with memData=8'hFF after a valid fetch of 8'h2A/8'h5C ->
//     upcode stays 4'h2, operandAddr stays 12'hA5C, seqError=1.
//  6. Reset mid-operation: in HAVE_OP, assert rst together with P2 -> ir2=0, irValid=0, pc=0, no error flagged.

Source files
------------

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_if
//  Brief    : Controller <-> fetch unit bundle (PC/IR controls, memory bus)
//  Revision : 1.0
// ============================================================================
interface fetch_unit_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12
);
    logic              pcWrite;
    logic              pcLoad;
    logic [ADDR_W-1:0] pcLoadValue;
    logic              memAddressSel;
    logic              IRwritePart1;
    logic              IRwritePart2;
    logic [DATA_W-1:0] memData;
    logic [ADDR_W-1:0] memAddress;
    logic [3:0]        upcode;
    logic [ADDR_W-1:0] operandAddr;
    logic [ADDR_W-1:0] pc;
    logic              irValid;
    logic              operandValid;
    logic              seqError;

    modport master (
        output pcWrite, pcLoad, pcLoadValue, memAddressSel,
               IRwritePart1, IRwritePart2, memData,
        input  memAddress, upcode, operandAddr, pc,
               irValid, operandValid, seqError
    );

    modport slave (
        input  pcWrite, pcLoad, pcLoadValue, memAddressSel,
               IRwritePart1, IRwritePart2, memData,
        output memAddress, upcode, operandAddr, pc,
               irValid, operandValid, seqError
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Brief    : Program counter, two-byte instruction register, address mux
//  Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter int                   DATA_W   = 8,
    parameter int                   ADDR_W   = 12,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  wire logic   clk,
    input  wire logic   rst,
    fetch_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HAVE_OP   = 2'd1,
        HAVE_ADDR = 2'd2
    } phase_t;

    phase_t            phase_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir1_q;
    logic [DATA_W-1:0] ir2_q;
    logic              irValid_q;
    logic              operandValid_q;
    logic              seqError_q;
    logic [ADDR_W-1:0] operandAddr_w;

    always_comb begin
        pc_d = pc_q;
        if (bus.pcLoad)
            pc_d = bus.pcLoadValue;
        else if (bus.pcWrite)
            pc_d = pc_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q           <= RESET_PC;
            ir1_q          <= '0;
            ir2_q          <= '0;
            phase_q        <= IDLE;
            irValid_q      <= 1'b0;
            operandValid_q <= 1'b0;
            seqError_q     <= 1'b0;
        end else begin
            pc_q <= pc_d;
            // Simultaneous strobes are illegal: flag and leave both IR bytes alone.
            case ({bus.IRwritePart1, bus.IRwritePart2})
                2'b11: seqError_q <= 1'b1;
                2'b10: begin
                    ir1_q          <= bus.memData;
                    phase_q        <= HAVE_OP;
                    irValid_q      <= 1'b1;
                    operandValid_q <= 1'b0;
                end
                2'b01: begin
                    if (phase_q == HAVE_OP) begin
                        ir2_q          <= bus.memData;
                        phase_q        <= HAVE_ADDR;
                        operandValid_q <= 1'b1;
                    end else begin
                        seqError_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign operandAddr_w    = {ir1_q[3:0], ir2_q};
    assign bus.operandAddr  = operandAddr_w;
    assign bus.upcode       = ir1_q[7:4];
    assign bus.pc           = pc_q;
    assign bus.memAddress   = bus.memAddressSel ? operandAddr_w : pc_q;
    assign bus.irValid      = irValid_q;
    assign bus.operandValid = operandValid_q;
    assign bus.seqError     = seqError_q;
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Brief    : Directed vector table plus hand sequences for fetch_unit
//  Revision : 1.0
// ============================================================================
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst;

    fetch_unit_if #(.DATA_W(8), .ADDR_W(12)) bus ();

    fetch_unit #(.DATA_W(8), .ADDR_W(12), .RESET_PC(12'h000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        pcW;
        logic        pcL;
        logic [11:0] pcV;
        logic        sel;
        logic        p1;
        logic        p2;
        logic [7:0]  md;
        logic [11:0] e_pc;
        logic [3:0]  e_up;
        logic [11:0] e_oa;
        logic        e_irv;
        logic        e_opv;
        logic        e_err;
        logic [11:0] e_ma;
    } vec_t;

    vec_t vq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic w, input logic l, input logic [11:0] v,
                       input logic s, input logic a, input logic b, input logic [7:0] m,
                       input logic [11:0] epc, input logic [3:0] eup, input logic [11:0] eoa,
                       input logic eiv, input logic eov, input logic eer, input logic [11:0] ema);
        vec_t t;
        t = '{r, w, l, v, s, a, b, m, epc, eup, eoa, eiv, eov, eer, ema};
        vq.push_back(t);
    endtask

    task automatic drive(input logic r, input logic w, input logic l, input logic [11:0] v,
                         input logic s, input logic a, input logic b, input logic [7:0] m);
        rst               = r;
        bus.pcWrite       = w;
        bus.pcLoad        = l;
        bus.pcLoadValue   = v;
        bus.memAddressSel = s;
        bus.IRwritePart1  = a;
        bus.IRwritePart2  = b;
        bus.memData       = m;
    endtask

    initial begin
        //   rst w l  pcV    s a b  md      pc      up    oa      iv ov er  ma
        add(1, 1, 1, 12'h123, 0, 1, 1, 8'hFF, 12'h000, 4'h0, 12'h000, 0, 0, 0, 12'h000);
        add(0, 1, 0, 12'h000, 0, 1, 0, 8'h2A, 12'h001, 4'h2, 12'hA00, 1, 0, 0, 12'h001);
        add(0, 1, 0, 12'h000, 1, 0, 1, 8'h5C, 12'h002, 4'h2, 12'hA5C, 1, 1, 0, 12'hA5C);
        add(0, 0, 0, 12'h000, 0, 0, 0, 8'h00, 12'h002, 4'h2, 12'hA5C, 1, 1, 0, 12'h002);
        add(0, 1, 0, 12'h000, 1, 1, 1, 8'hFF, 12'h003, 4'h2, 12'hA5C, 1, 1, 1, 12'hA5C);
        add(0, 0, 1, 12'hFFF, 0, 0, 0, 8'h00, 12'hFFF, 4'h2, 12'hA5C, 1, 1, 1, 12'hFFF);
        add(0, 1, 0, 12'h000, 0, 0, 0, 8'h00, 12'h000, 4'h2, 12'hA5C, 1, 1, 1, 12'h000);
        add(0, 1, 1, 12'h123, 0, 0, 0, 8'h00, 12'h123, 4'h2, 12'hA5C, 1, 1, 1, 12'h123);
        add(0, 0, 0, 12'h000, 1, 1, 0, 8'h31, 12'h123, 4'h3, 12'h15C, 1, 0, 1, 12'h15C);
        add(0, 0, 0, 12'h000, 1, 1, 0, 8'h47, 12'h123, 4'h4, 12'h75C, 1, 0, 1, 12'h75C);
        add(1, 0, 0, 12'h000, 0, 0, 0, 8'h00, 12'h000, 4'h0, 12'h000, 0, 0, 0, 12'h000);
        add(0, 0, 0, 12'h000, 0, 0, 1, 8'h99, 12'h000, 4'h0, 12'h000, 0, 0, 1, 12'h000);
        add(0, 0, 0, 12'h000, 1, 1, 0, 8'h80, 12'h000, 4'h8, 12'h000, 1, 0, 1, 12'h000);
        add(1, 0, 0, 12'h000, 0, 0, 0, 8'h00, 12'h000, 4'h0, 12'h000, 0, 0, 0, 12'h000);
        add(0, 0, 0, 12'h000, 0, 1, 0, 8'h2A, 12'h000, 4'h2, 12'hA00, 1, 0, 0, 12'h000);
        add(1, 1, 0, 12'h000, 0, 0, 1, 8'h5C, 12'h000, 4'h0, 12'h000, 0, 0, 0, 12'h000);
        add(0, 0, 0, 12'h000, 1, 1, 0, 8'h1B, 12'h000, 4'h1, 12'hB00, 1, 0, 0, 12'hB00);
        add(0, 0, 0, 12'h000, 1, 0, 1, 8'h22, 12'h000, 4'h1, 12'hB22, 1, 1, 0, 12'hB22);
        add(0, 0, 0, 12'h000, 1, 0, 1, 8'h33, 12'h000, 4'h1, 12'hB22, 1, 1, 1, 12'hB22);

        drive(1, 0, 0, 12'h000, 0, 0, 0, 8'h00);
        @(posedge clk);

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].rst, vq[i].pcW, vq[i].pcL, vq[i].pcV,
                  vq[i].sel, vq[i].p1, vq[i].p2, vq[i].md);
            @(posedge clk);
            #1;
            check($sformatf("v%0d.pc", i),    bus.pc,                   vq[i].e_pc);
            check($sformatf("v%0d.up", i),    {8'h0, bus.upcode},       {8'h0, vq[i].e_up});
            check($sformatf("v%0d.oa", i),    bus.operandAddr,          vq[i].e_oa);
            check($sformatf("v%0d.irv", i),   {11'h0, bus.irValid},     {11'h0, vq[i].e_irv});
            check($sformatf("v%0d.opv", i),   {11'h0, bus.operandValid},{11'h0, vq[i].e_opv});
            check($sformatf("v%0d.err", i),   {11'h0, bus.seqError},    {11'h0, vq[i].e_err});
            check($sformatf("v%0d.ma", i),    bus.memAddress,           vq[i].e_ma);
        end

        // memAddress follows the select with no clock in between (ir = 1B/22, pc = 0)
        @(negedge clk);
        drive(0, 0, 0, 12'h000, 0, 0, 0, 8'h00);
        #1;
        check("mux_pc", bus.memAddress, 12'h000);
        bus.memAddressSel = 1'b1;
        #1;
        check("mux_op", bus.memAddress, 12'hB22);

        // Twenty consecutive increments from reset, then hold
        @(negedge clk);
        drive(1, 0, 0, 12'h000, 0, 0, 0, 8'h00);
        @(negedge clk);
        drive(0, 1, 0, 12'h000, 0, 0, 0, 8'h00);
        repeat (20) @(posedge clk);
        #1;
        check("inc20", bus.pc, 12'd20);
        @(negedge clk);
        bus.pcWrite = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("hold", bus.pc, 12'd20);
        check("hold_err", {11'h0, bus.seqError}, 12'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
